// File: rtl/alu_control_sequencer.sv
// Moore control sequencer for the DataPath: fetch (T0-T2), decode (T3) and
// three-register ALU execute (T4-T5), plus nop/halt/illegal handling.
module alu_control_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_BITS  = 5,
  parameter int REG_SEL_BITS = 4,
  parameter int CNT_WIDTH    = 16,
  localparam int NREG        = 2**REG_SEL_BITS
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Mem_ready,
  input  logic [DATA_WIDTH-1:0]  IR,
  output logic                   PCout,
  output logic                   Zlowout,
  output logic                   MDRout,
  output logic                   MARin,
  output logic                   Zin,
  output logic                   PCin,
  output logic                   MDRin,
  output logic                   IRin,
  output logic                   Yin,
  output logic                   IncPC,
  output logic                   Read,
  output logic [NREG-1:0]        Rout,
  output logic [NREG-1:0]        Rin,
  output logic [OPCODE_BITS-1:0] ALU_op,
  output logic                   Running,
  output logic                   Illegal,
  output logic [CNT_WIDTH-1:0]   Instr_count
);

  // state | meaning
  // IDLE  | waiting for Start
  // T0    | PC to MAR, PC+1 into Z
  // T1    | Z to PC, memory read, waits for Mem_ready
  // T2    | MDR to IR
  // T3    | decode; ALU: Rb to Y
  // T4    | ALU: Rc with op into Z
  // T5    | ALU: Z to Ra, retire
  // HALT  | stopped until reset
  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  localparam int RA_MSB = DATA_WIDTH - OPCODE_BITS - 1;
  localparam int RB_MSB = RA_MSB - REG_SEL_BITS;
  localparam int RC_MSB = RB_MSB - REG_SEL_BITS;

  localparam logic [OPCODE_BITS-1:0] OP_ALU_LO = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_ALU_HI = OPCODE_BITS'(10);
  localparam logic [OPCODE_BITS-1:0] OP_NOP    = OPCODE_BITS'(30);
  localparam logic [OPCODE_BITS-1:0] OP_HALT   = OPCODE_BITS'(31);

  state_t state, next_state;
  logic   stop_q;
  logic   retire;
  logic [OPCODE_BITS-1:0]  op_q;
  logic [REG_SEL_BITS-1:0] ra_q, rc_q;
  logic [CNT_WIDTH-1:0]    count_q;

  logic [OPCODE_BITS-1:0]  op_cur;
  logic [REG_SEL_BITS-1:0] ra_cur, rb_cur, rc_cur;
  logic                    is_alu;
  logic                    unused_ir;

  assign op_cur    = IR[DATA_WIDTH-1 -: OPCODE_BITS];
  assign ra_cur    = IR[RA_MSB -: REG_SEL_BITS];
  assign rb_cur    = IR[RB_MSB -: REG_SEL_BITS];
  assign rc_cur    = IR[RC_MSB -: REG_SEL_BITS];
  assign is_alu    = (op_cur >= OP_ALU_LO) && (op_cur <= OP_ALU_HI);
  assign unused_ir = ^IR;

  assign Running     = (state != S_IDLE) && (state != S_HALT);
  assign Instr_count = count_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      stop_q  <= 1'b0;
      count_q <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rc_q    <= '0;
    end else begin
      state <= next_state;
      // Entering IDLE consumes the stop request, even if Stop is still high.
      if (next_state == S_IDLE && state != S_IDLE)
        stop_q <= 1'b0;
      else if (Stop)
        stop_q <= 1'b1;
      if (retire && count_q != {CNT_WIDTH{1'b1}})
        count_q <= count_q + 1'b1;
      if (state == S_T3) begin
        op_q <= op_cur;
        ra_q <= ra_cur;
        rc_q <= rc_cur;
      end
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    PCout   = 1'b0;  Zlowout = 1'b0;  MDRout = 1'b0;  MARin = 1'b0;
    Zin     = 1'b0;  PCin    = 1'b0;  MDRin  = 1'b0;  IRin  = 1'b0;
    Yin     = 1'b0;  IncPC   = 1'b0;  Read   = 1'b0;
    Rout    = '0;
    Rin     = '0;
    ALU_op  = '0;
    Illegal = 1'b0;
    case (state)
      S_IDLE: if (Start) next_state = S_T0;
      S_T0: begin
        PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  Zin = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;  PCin = 1'b1;  Read = 1'b1;  MDRin = 1'b1;
        if (Mem_ready) next_state = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;  IRin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          Rout       = NREG'(1) << rb_cur;
          Yin        = 1'b1;
          next_state = S_T4;
        end else if (op_cur == OP_NOP) begin
          retire     = 1'b1;
          next_state = stop_q ? S_IDLE : S_T0;
        end else if (op_cur == OP_HALT) begin
          retire     = 1'b1;
          next_state = S_HALT;
        end else begin
          Illegal    = 1'b1;
          next_state = stop_q ? S_IDLE : S_T0;
        end
      end
      S_T4: begin
        Rout       = NREG'(1) << rc_q;
        ALU_op     = op_q;
        Zin        = 1'b1;
        next_state = S_T5;
      end
      S_T5: begin
        Zlowout    = 1'b1;
        Rin        = NREG'(1) << ra_q;
        retire     = 1'b1;
        next_state = stop_q ? S_IDLE : S_T0;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized bench for alu_control_sequencer: each instruction is expanded into
// its expected per-cycle strobe pattern and compared cycle by cycle.
module tb_alu_control_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn, Start, Stop, Mem_ready;
  logic [31:0] IR;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [15:0] Rout, Rin;
  logic [4:0]  ALU_op;
  logic        Running, Illegal;
  logic [15:0] Instr_count;

  alu_control_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .Mem_ready(Mem_ready), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin), .ALU_op(ALU_op),
    .Running(Running), .Illegal(Illegal), .Instr_count(Instr_count)
  );

  always #5 Clock = ~Clock;

  // strobe bits: PCout Zlowout MDRout MARin Zin PCin MDRin IRin Yin IncPC Read
  localparam logic [10:0] B_PCOUT = 11'h400, B_ZLOW = 11'h200, B_MDROUT = 11'h100,
                          B_MARIN = 11'h080, B_ZIN  = 11'h040, B_PCIN   = 11'h020,
                          B_MDRIN = 11'h010, B_IRIN = 11'h008, B_YIN    = 11'h004,
                          B_INCPC = 11'h002, B_READ = 11'h001;

  int n_cmp = 0;
  int n_err = 0;
  int mdl_count = 0;
  bit mdl_idle  = 1'b1;
  bit mdl_halt  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] mk(input logic [10:0] s, input logic [15:0] ro,
                                     input logic [15:0] ri, input logic [4:0] op,
                                     input logic run, input logic ill);
    return {s, ro, ri, op, run, ill};
  endfunction

  function automatic logic [49:0] act();
    return {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
            Rout, Rin, ALU_op, Running, Illegal};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_start(input bit with_stop);
    chk("idle", 64'(act()), 64'(mk(0, 0, 0, 0, 0, 0)));
    Start = 1'b1;
    Stop  = with_stop;
    step();
    Start = 1'b0;
    Stop  = 1'b0;
    mdl_idle = 1'b0;
  endtask

  // stop_at: cycle index of a Stop pulse, -1 for none, -2 for a random choice.
  task automatic run_instr(input logic [31:0] ir, input int w, input int stop_at,
                           input bit stop_pre);
    logic [49:0] q[$];
    logic [4:0]  op;
    int          ra, rb, rc, mr_idx, sa;
    bit          alu, nop, hlt, stopped;
    op  = ir[31:27];
    ra  = int'(ir[26:23]);
    rb  = int'(ir[22:19]);
    rc  = int'(ir[18:15]);
    alu = (op >= 3 && op <= 10);
    nop = (op == 30);
    hlt = (op == 31);
    IR  = ir;
    q.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0, 0, 0, 1, 0));
    for (int k = 0; k <= w; k++)
      q.push_back(mk(B_ZLOW | B_PCIN | B_READ | B_MDRIN, 0, 0, 0, 1, 0));
    mr_idx = 1 + w;
    q.push_back(mk(B_MDROUT | B_IRIN, 0, 0, 0, 1, 0));
    if (alu) begin
      q.push_back(mk(B_YIN, 16'd1 << rb, 0, 0, 1, 0));
      q.push_back(mk(B_ZIN, 16'd1 << rc, 0, op, 1, 0));
      q.push_back(mk(B_ZLOW, 0, 16'd1 << ra, 0, 1, 0));
    end else begin
      q.push_back(mk(0, 0, 0, 0, 1, (nop || hlt) ? 1'b0 : 1'b1));
    end
    sa = stop_at;
    if (sa == -2)
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 2)) : -1;
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("op%0d_cyc%0d", op, i), 64'(act()), 64'(q[i]));
      if (i == mr_idx)     Mem_ready = 1'b1;
      else if (i >= 1 && i < mr_idx) Mem_ready = 1'b0;
      else                 Mem_ready = 1'($urandom_range(0, 1));
      Stop = (i == sa);
      step();
      Stop = 1'b0;
    end
    stopped = stop_pre || (sa >= 0);
    if (alu || nop || hlt)
      mdl_count = (mdl_count == 16'hFFFF) ? mdl_count : mdl_count + 1;
    if (hlt)          mdl_halt = 1'b1;
    else if (stopped) mdl_idle = 1'b1;
    chk("instr_count", 64'(Instr_count), 64'(mdl_count));
  endtask

  function automatic logic [31:0] rnd_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = op;
    return r;
  endfunction

  function automatic logic [4:0] rnd_illegal();
    logic [4:0] op;
    do op = 5'($urandom_range(0, 31)); while ((op >= 3 && op <= 10) || op >= 30);
    return op;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; Start = 1'b0; Stop = 1'b0; Mem_ready = 1'b0; IR = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_out", 64'(act()), 64'(mk(0, 0, 0, 0, 0, 0)));
    chk("reset_cnt", 64'(Instr_count), 64'd0);
    Resetn = 1'b1;
    step();

    // reference ALU instruction, no memory wait
    do_start(1'b0);
    run_instr(32'h2891_8000, 0, -1, 1'b0);
    // three wait cycles in T1
    run_instr(rnd_ir(5'd7), 3, -1, 1'b0);
    // illegal opcode 20
    run_instr(rnd_ir(5'd20), 0, -1, 1'b0);
    // Stop during T1 of an ALU op, then fresh Start
    run_instr(rnd_ir(5'd4), 1, 1, 1'b0);
    do_start(1'b0);
    run_instr(rnd_ir(5'd30), 0, -1, 1'b0);
    // Start and Stop together in IDLE: one instruction, back to IDLE
    run_instr(rnd_ir(5'd10), 0, 0, 1'b0);
    do_start(1'b1);
    run_instr(rnd_ir(5'd3), 2, -1, 1'b1);

    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      bit         pre;
      int         sel;
      pre = 1'b0;
      if (mdl_idle) begin
        repeat ($urandom_range(0, 2)) begin
          chk("idle_wait", 64'(act()), 64'(mk(0, 0, 0, 0, 0, 0)));
          step();
        end
        pre = ($urandom_range(0, 7) == 0);
        do_start(pre);
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      op = 5'($urandom_range(3, 10));
      else if (sel < 8) op = 5'd30;
      else              op = rnd_illegal();
      run_instr(rnd_ir(op), int'($urandom_range(0, 3)), -2, pre);
    end

    // asynchronous reset in T4
    if (mdl_idle) do_start(1'b0);
    IR = rnd_ir(5'd9);
    Mem_ready = 1'b1;
    repeat (4) step();
    chk("t4_zin", 64'(Zin), 64'd1);
    chk("t4_aluop", 64'(ALU_op), 64'd9);
    #2 Resetn = 1'b0;
    #1;
    chk("async_rst_out", 64'(act()), 64'(mk(0, 0, 0, 0, 0, 0)));
    chk("async_rst_cnt", 64'(Instr_count), 64'd0);
    mdl_count = 0;
    mdl_idle  = 1'b1;
    step();
    Resetn = 1'b1;
    step();

    // halt: Start afterwards is ignored
    do_start(1'b0);
    run_instr(rnd_ir(5'd31), 1, -1, 1'b0);
    chk("halt_out", 64'(act()), 64'(mk(0, 0, 0, 0, 0, 0)));
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("halt_after_start", 64'(act()), 64'(mk(0, 0, 0, 0, 0, 0)));
    step();
    chk("halt_hold", 64'(act()), 64'(mk(0, 0, 0, 0, 0, 0)));
    chk("halt_cnt", 64'(Instr_count), 64'(mdl_count));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
